hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
// Pipeline hazard controller for the 5-stage RV32 core; drives the control side of the F/D, D/E, E/M and M/W registers.
// Produces forwarding selects, load-use stall/bubble, branch flush (FlushE is the D/E register CLR) and whole-pipe freeze on data-memory wait.
// Sequential part: wait-state FSM with timeout watchdog, plus saturating stall/flush performance counters.
// PARAMETERS
// CNT_W      32   width of perf counters stall_cnt / flush_cnt (saturate at all-ones)
// TIMEOUT    256  consecutive mem_stall cycles that trip mem_timeout (>=2)
// LOAD_SRC   2'b01 ResultSrcE encoding of a load
// PORTS
// clk          in   1      rising-edge clock
// rst          in   1      asynchronous, active-high reset
// Rs1D, Rs2D   in   5      source regs of instruction in Decode
// Rs1E, Rs2E   in   5      source regs in Execute
// RdE, RdM, RdW in  5      destination regs in E/M/W
// ResultSrcE   in   2      result select in Execute (LOAD_SRC = load)
// RegWriteM, RegWriteW in 1 write-enable in M/W
// PCSrcE       in   1      branch/jump taken, resolved in Execute
// mem_stall    in   1      data memory not ready this cycle (level)
// ForwardAE, ForwardBE out 2 00=RF, 10=ALUResultM, 01=ResultW
// StallF, StallD out 1     hold PC / F-D register
// StallE, StallM out 1     hold D-E / E-M registers (memory wait only)
// FlushD       out  1      clear F/D register
// FlushE       out  1      clear D/E register (CLR)
// mem_timeout  out  1      sticky watchdog error
// stall_cnt    out  CNT_W  cycles with StallF=1
// flush_cnt    out  CNT_W  cycles with FlushE=1 due to PCSrcE
// BEHAVIOUR
// - Forwarding (combinational, every cycle): ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 00. Same for B with Rs2E. M beats W.
// - lwstall = (ResultSrcE==LOAD_SRC) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
// - Priority per cycle: rst > mem_stall > PCSrcE > lwstall.
//   mem_stall=1: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0 (pipe frozen, flushes deferred; PCSrcE stays valid since E frozen).
//   else PCSrcE=1: FlushD=FlushE=1, StallF=StallD=0 (branch kills younger load-use pair).
//   else lwstall=1: StallF=StallD=1, FlushE=1 (one bubble), FlushD=0.
//   else: all stall/flush 0. StallE/StallM only ever 1 under mem_stall.
// - Stall/flush/forward outputs are combinational from inputs and state; zero-latency (same cycle as cause).
// - FSM (registered): RUN, MEMWAIT, ERR.
//   RUN: mem_stall=1 -> MEMWAIT, wait_cnt<=1.
//   MEMWAIT: mem_stall=0 -> RUN; mem_stall=1 and wait_cnt==TIMEOUT-1 -> ERR; else wait_cnt++.
//   ERR: mem_timeout=1; output logic continues as above; leaves only on rst.
// - mem_timeout = (state==ERR); registered, asserts the cycle after the TIMEOUT-th consecutive stalled cycle.
// - Counters update on clk edge: stall_cnt +1 if StallF; flush_cnt +1 if FlushE && PCSrcE && !mem_stall. Saturate, never wrap.
// - Reset (async, mid-operation included): state=RUN, wait_cnt=0, counters=0, mem_timeout=0; while rst=1 all stall/flush outputs forced 0 and Forward*=00.
// - Boundary: x0 never forwarded or stalled on; mem_stall pulse of 1 cycle -> MEMWAIT for exactly 1 cycle; mem_stall dropping on the cycle wait_cnt==TIMEOUT-1 -> RUN, no error.
// TESTING
// 1. RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10; RdM=0 same -> ForwardAE=01; Rs2E=0,RdW=0 -> ForwardBE=00.
// 2. ResultSrcE=01,RdE=7,Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0, stall_cnt +1; RdE=0 -> no stall.
// 3. lwstall and PCSrcE both 1 -> FlushD=FlushE=1, StallF=0, flush_cnt +1, stall_cnt unchanged.
// 4. mem_stall high 3 cycles with PCSrcE=1 -> all Stall*=1, Flush*=0 for 3 cycles, then FlushD/E=1 on release; stall_cnt +3, flush_cnt +1.
// 5. TIMEOUT=4, mem_stall held 6 cycles -> mem_timeout=1 from cycle 5 and sticky after release; rst pulse -> 0, counters 0.
// 6. CNT_W=4, 20 lwstall cycles -> stall_cnt=15 holds; rst asserted mid-MEMWAIT -> outputs 0 immediately, state RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage RV32 pipeline: forwarding, load-use stall, branch flush,
// memory-wait freeze with timeout watchdog, and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int         CNT_W    = 32,
    parameter int         TIMEOUT  = 256,
    parameter logic [1:0] LOAD_SRC = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             mem_stall,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WC_W    = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    state_t           r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lwstall;
    logic w_fwd_a_m, w_fwd_a_w, w_fwd_b_m, w_fwd_b_w;

    assign w_lwstall = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));

    assign w_fwd_a_m = RegWriteM && (RdM != 5'd0) && (RdM == Rs1E);
    assign w_fwd_a_w = RegWriteW && (RdW != 5'd0) && (RdW == Rs1E);
    assign w_fwd_b_m = RegWriteM && (RdM != 5'd0) && (RdM == Rs2E);
    assign w_fwd_b_w = RegWriteW && (RdW != 5'd0) && (RdW == Rs2E);

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        if (!rst) begin
            if (w_fwd_a_m)      ForwardAE = 2'b10;
            else if (w_fwd_a_w) ForwardAE = 2'b01;
            if (w_fwd_b_m)      ForwardBE = 2'b10;
            else if (w_fwd_b_w) ForwardBE = 2'b01;

            // Memory wait freezes everything; a taken branch stays valid in frozen E.
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (w_lwstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_stall) begin
                        r_state    <= MEMWAIT;
                        r_wait_cnt <= WC_W'(1);
                    end
                end
                MEMWAIT: begin
                    if (!mem_stall) begin
                        r_state <= RUN;
                    end else if (r_wait_cnt == WC_LAST) begin
                        r_state <= ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WC_W'(1);
                    end
                end
                ERR:     r_state <= ERR;
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallF && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (FlushE && PCSrcE && !mem_stall && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign mem_timeout = (r_state == ERR);
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
